// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Central stall/flush controller for a 5-stage RISC-V pipeline.
// Detects load-use hazards and taken-branch redirects, and freezes the whole
// pipeline for MEM_WAIT cycles on each data-memory access.
//
// Parameters:
//   MEM_WAIT        data-memory wait states per load/store (0..15), 0 = none
// Ports:
//   clk             pipeline clock, rising edge
//   rst             asynchronous, active-low reset
//   id_rs1/id_rs2   ID-stage source registers; id_uses_rs1/2 qualify them
//   ex_valid        EX holds a valid instruction
//   ex_mem_read     EX instruction is a load; ex_rd is its destination
//   ex_branch_taken EX resolved a taken branch/jump
//   mem_access      MEM holds a valid load/store
//   pc_en, ifid_en, idex_en, exmem_en   per-stage load enables
//   ifid_flush, idex_flush, memwb_bubble valid-clear strobes
//   mem_busy        memory-stall FSM is not in RUN
//   stall_cycles    count of cycles with pc_en low (saturating)
// Configuration:
//   HAZARD_PERF_CNT_EN  when defined, builds the stall_cycles counter;
//                       otherwise stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_bubble,
  output logic        mem_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_GRANT
  } state_e;

  localparam bit         MEM_STALL_EN = (MEM_WAIT != 0);
  // WAIT spans MEM_WAIT-1 cycles; the RUN cycle that sees mem_access is the first.
  localparam logic [3:0] WAIT_LOAD    = (MEM_WAIT >= 2) ? 4'(MEM_WAIT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_stall;
  logic       load_use;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_access && MEM_STALL_EN) begin
          if (MEM_WAIT == 1) begin
            state_d = ST_GRANT;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_GRANT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_GRANT: begin
        // mem_access still reflects the instruction just granted; ignore it.
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign mem_stall = ((state_q == ST_RUN) && mem_access && MEM_STALL_EN) ||
                     (state_q == ST_WAIT);
  assign mem_busy  = (state_q != ST_RUN);

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (mem_stall) begin
      // Freeze everything; a held branch is acted on once the stall ends.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold IF and ID, push a bubble into EX while the load advances.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 32'd0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read;
  logic       ex_branch_taken, mem_access;

  // Outputs packed as {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //                    exmem_en, memwb_bubble, mem_busy}
  logic        pc3, ifen3, iff3, iden3, idf3, exen3, bub3, busy3;
  logic        pc0, ifen0, iff0, iden0, idf0, exen0, bub0, busy0;
  logic [31:0] cnt3, cnt0;
  logic [7:0]  out3, out0;

  assign out3 = {pc3, ifen3, iff3, iden3, idf3, exen3, bub3, busy3};
  assign out0 = {pc0, ifen0, iff0, iden0, idf0, exen0, bub0, busy0};

  always #5 clk = ~clk;

  hazard_unit #(.MEM_WAIT(3)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .pc_en(pc3), .ifid_en(ifen3), .ifid_flush(iff3), .idex_en(iden3),
    .idex_flush(idf3), .exmem_en(exen3), .memwb_bubble(bub3),
    .mem_busy(busy3), .stall_cycles(cnt3)
  );

  hazard_unit #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .pc_en(pc0), .ifid_en(ifen0), .ifid_flush(iff0), .idex_en(iden0),
    .idex_flush(idf0), .exmem_en(exen0), .memwb_bubble(bub0),
    .mem_busy(busy0), .stall_cycles(cnt0)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory stall viewed as "stall cycles still owed" plus a one-cycle grant.
  int          wait_cfg [2] = '{3, 0};
  int          owed     [2];
  bit          grant    [2];
  logic [31:0] m_cnt    [2];

  function automatic logic [7:0] model_out(input int left, input bit gr, input int w);
    bit stalled, busy, hazard;
    stalled = (left > 0) || (!gr && mem_access && (w != 0));
    busy    = (left > 0) || gr;
    hazard  = ex_valid && ex_mem_read && (ex_rd != 0) &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (stalled)              return {6'b000000, 1'b1, busy};
    else if (ex_branch_taken) return {6'b111111, 1'b0, busy};
    else if (hazard)          return {6'b000111, 1'b0, busy};
    else                      return {6'b110101, 1'b0, busy};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        owed[i] = 0; grant[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] o;
        o = model_out(owed[i], grant[i], wait_cfg[i]);
        if (!o[7] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
        if (owed[i] > 0) begin
          owed[i] = owed[i] - 1;
          if (owed[i] == 0) grant[i] = 1;
        end else if (grant[i]) begin
          grant[i] = 0;
        end else if (mem_access && wait_cfg[i] != 0) begin
          owed[i] = wait_cfg[i] - 1;
          if (owed[i] == 0) grant[i] = 1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_cnt(input int i);
`ifdef HAZARD_PERF_CNT_EN
    return m_cnt[i];
`else
    return 32'd0;
`endif
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("cmp_w3_out", {24'd0, out3}, {24'd0, model_out(owed[0], grant[0], 3)});
      check("cmp_w0_out", {24'd0, out0}, {24'd0, model_out(owed[1], grant[1], 0)});
      check("cmp_w3_cnt", cnt3, exp_cnt(0));
      check("cmp_w0_cnt", cnt0, exp_cnt(1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic chk_out(input string name, input logic [7:0] exp);
    @(negedge clk); #1;
    check(name, {24'd0, out3}, {24'd0, exp});
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_access = 0;
  endtask

  task automatic set_load_use();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
  endtask

  localparam logic [7:0] RUN_OK   = 8'b1101_0100;
  localparam logic [7:0] GRANT_OK = 8'b1101_0101;
  localparam logic [7:0] LU_STALL = 8'b0001_1100;
  localparam logic [7:0] BR_FLUSH = 8'b1111_1100;
  localparam logic [7:0] MS_FIRST = 8'b0000_0010;
  localparam logic [7:0] MS_WAIT  = 8'b0000_0011;

  initial begin
    rst = 0;
    clear_in();
    repeat (2) @(posedge clk);
    #2 rst = 1;

    chk_out("reset_outputs", RUN_OK);
    check("reset_count", cnt3, 32'd0);

    cyc(); set_load_use();
    chk_out("load_use_stall", LU_STALL);
    cyc(); ex_rd = 0; id_rs2 = 0;
    chk_out("x0_no_stall", RUN_OK);

    // MEM_WAIT=3, mem_access held through t+4.
    cyc(); clear_in(); mem_access = 1;
    chk_out("mem_t0", MS_FIRST);
    check("w0_no_stall", {24'd0, out0}, {24'd0, RUN_OK});
    cyc(); chk_out("mem_t1", MS_WAIT);
    cyc(); chk_out("mem_t2", MS_WAIT);
    cyc(); chk_out("mem_grant", GRANT_OK);
    cyc(); chk_out("mem_restart", MS_FIRST);
    cyc(); mem_access = 0;
    chk_out("mem2_t1", MS_WAIT);
    cyc(); chk_out("mem2_t2", MS_WAIT);
    cyc(); chk_out("mem2_grant", GRANT_OK);
    cyc(); chk_out("mem2_run", RUN_OK);

    // Branch beats load-use; then branch held across a memory stall.
    cyc(); set_load_use(); ex_branch_taken = 1;
    chk_out("branch_over_lu", BR_FLUSH);
    cyc(); mem_access = 1;
    chk_out("br_mem_t0", MS_FIRST);
    cyc(); chk_out("br_mem_t1", MS_WAIT);
    cyc(); chk_out("br_mem_t2", MS_WAIT);
    cyc(); chk_out("br_mem_grant", BR_FLUSH | 8'b0000_0001);
    cyc(); clear_in();
    chk_out("br_mem_run", RUN_OK);

    // Reset in the middle of WAIT aborts the stall at once.
    cyc(); mem_access = 1;
    chk_out("rst_t0", MS_FIRST);
    cyc(); mem_access = 0;
    chk_out("rst_wait", MS_WAIT);
    #1 rst = 0;
    #1 check("rst_abort_out", {24'd0, out3}, {24'd0, RUN_OK});
    check("rst_abort_count", cnt3, 32'd0);
    @(posedge clk); #2 rst = 1;
    chk_out("rst_after", RUN_OK);

    // Ten separate load-use stalls.
    for (int i = 0; i < 10; i++) begin
      cyc(); set_load_use();
      cyc(); clear_in();
    end
    chk_out("perf_run", RUN_OK);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_count10", cnt3, 32'd10);
    check("perf_count10_w0", cnt0, 32'd10);
`else
    check("perf_tied0", cnt3, 32'd0);
    check("perf_tied0_w0", cnt0, 32'd0);
`endif

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
